// File: rtl/serial_nibble_subtractor_pkg.sv
// Shared types and constants for the serial nibble subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Counter width for a given slice count; never narrower than one bit.
    function automatic int cnt_width(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/sub_slice4.sv
// Combinational 4-bit full subtractor: {bo, d} = x - y - bi.
module sub_slice4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    // The fifth bit of the widened difference is the borrow out.
    assign {bo, d} = {1'b0, x} - {1'b0, y} - {4'b0000, bi};

endmodule

// File: rtl/serial_nibble_subtractor.sv
// Wide subtractor computing a - b - bin one nibble per clock, LSB slice first.
module serial_nibble_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = cnt_width(NSLICE);
    localparam int NENT   = 1 << CW;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             borrow_reg, borrow_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             bout_reg, bout_next;

    logic [3:0]       a_sl [NENT];
    logic [3:0]       b_sl [NENT];
    logic [3:0]       slice_x, slice_y, slice_d;
    logic             slice_bo;
    logic [WIDTH-1:0] diff_merged;

    // Slice tables are padded to the full counter range so every index is legal.
    genvar gi;
    generate
        for (gi = 0; gi < NENT; gi++) begin : g_sel
            if (gi < NSLICE) begin : g_real
                assign a_sl[gi] = a_reg[gi*SLICE_W +: SLICE_W];
                assign b_sl[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            end else begin : g_pad
                assign a_sl[gi] = 4'h0;
                assign b_sl[gi] = 4'h0;
            end
        end
        for (gi = 0; gi < NSLICE; gi++) begin : g_wr
            assign diff_merged[gi*SLICE_W +: SLICE_W] =
                (cnt_reg == CW'(gi)) ? slice_d : diff_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign slice_x = a_sl[cnt_reg];
    assign slice_y = b_sl[cnt_reg];

    sub_slice4 u_slice (
        .x  (slice_x),
        .y  (slice_y),
        .bi (borrow_reg),
        .d  (slice_d),
        .bo (slice_bo)
    );

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        borrow_next = borrow_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        diff_next   = diff_reg;
        bout_next   = bout_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bin;
                    cnt_next    = '0;
                    diff_next   = '0;
                    bout_next   = 1'b0;
                    state_next  = RUN;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                diff_next   = diff_merged;
                borrow_next = slice_bo;
                if (cnt_reg == LAST) begin
                    cnt_next   = '0;
                    bout_next  = slice_bo;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            borrow_reg <= 1'b0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            borrow_reg <= borrow_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            bout_reg   <= bout_next;
        end
    end

    assign ready = (state_reg == IDLE) || (state_reg == DONE);
    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign diff  = diff_reg;
    assign bout  = bout_reg;

endmodule

// File: tb/tb_serial_nibble_subtractor.sv
// Directed self-checking bench for serial_nibble_subtractor (16-bit and 4-bit instances).
module tb_serial_nibble_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        ready, busy, done;
    logic [15:0] diff;
    logic        bout;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        bin4;
    logic        ready4, busy4, done4;
    logic [3:0]  diff4;
    logic        bout4;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    serial_nibble_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_nibble_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, count edges until done, check latency and result.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic bv_in, input logic [15:0] exp_d, input logic exp_bo);
        int edges;
        a = av; b = bv; bin = bv_in; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0;
        while (!done && edges < 10) begin
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, 4);
        check({tag, "_diff"}, {16'h0, diff}, {16'h0, exp_d});
        check({tag, "_bout"}, {31'h0, bout}, {31'h0, exp_bo});
        $display("op %s: a=%h b=%h bin=%0d -> diff=%h bout=%0d", tag, av, bv, bv_in, diff, bout);
        tick();
        check({tag, "_idle_done"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        int gap;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_done",  {31'h0, done}, 32'h0);
        check("rst_diff",  {16'h0, diff}, 32'h0);
        check("rst_bout",  {31'h0, bout}, 32'h0);
        check("rst4_ready", {31'h0, ready4}, 32'h1);
        rst = 1'b0;
        tick();

        // 1: latency and ready/busy profile
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 4; e++) begin
            check("t1_ready_low", {31'h0, ready}, 32'h0);
            check("t1_busy_high", {31'h0, busy}, 32'h1);
            check("t1_no_done", {31'h0, done}, 32'h0);
            tick();
        end
        check("t1_done", {31'h0, done}, 32'h1);
        check("t1_diff", {16'h0, diff}, 32'h1000);
        check("t1_bout", {31'h0, bout}, 32'h0);
        $display("op t1: a=1234 b=0234 bin=0 -> diff=%h bout=%0d", diff, bout);
        tick();
        check("t1_idle_done", {31'h0, done}, 32'h0);
        check("t1_hold_diff", {16'h0, diff}, 32'h1000);

        // 2: full borrow ripple
        run_op("t2a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
        run_op("t2b", 16'h0001, 16'h0001, 1'b1, 16'hFFFF, 1'b1);

        // 3: start during RUN ignored
        a = 16'hFFFF; b = 16'h5555; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'h0000; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t3_done", {31'h0, done}, 32'h1);
        check("t3_diff", {16'h0, diff}, 32'hAAAA);
        check("t3_bout", {31'h0, bout}, 32'h0);
        $display("op t3: a=FFFF b=5555 bin=0 -> diff=%h bout=%0d", diff, bout);
        tick();
        check("t3_hold_diff", {16'h0, diff}, 32'hAAAA);

        // 4: reset mid-RUN aborts
        a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_ready", {31'h0, ready}, 32'h1);
        check("t4_diff",  {16'h0, diff}, 32'h0);
        check("t4_bout",  {31'h0, bout}, 32'h0);
        for (int e = 0; e < 5; e++) begin
            check("t4_no_done", {31'h0, done}, 32'h0);
            tick();
        end
        $display("op t4: aborted by reset, diff=%h", diff);
        run_op("t4b", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0);

        // 5: back-to-back via start in DONE
        a = 16'h00FF; b = 16'h0010; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        check("t5a_done", {31'h0, done}, 32'h1);
        check("t5a_diff", {16'h0, diff}, 32'h00EE);
        check("t5a_bout", {31'h0, bout}, 32'h0);
        $display("op t5a: a=00FF b=0010 bin=1 -> diff=%h bout=%0d", diff, bout);
        a = 16'h1000; b = 16'h2000; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_accept_busy", {31'h0, busy}, 32'h1);
        gap = 1;
        while (!done && gap < 12) begin
            tick();
            gap++;
        end
        check("t5_gap", gap, 5);
        check("t5b_diff", {16'h0, diff}, 32'hF000);
        check("t5b_bout", {31'h0, bout}, 32'h1);
        $display("op t5b: a=1000 b=2000 bin=0 -> diff=%h bout=%0d", diff, bout);
        tick();

        // 6: 4-bit instance
        a4 = 4'h1; b4 = 4'h2; bin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("t6_busy", {31'h0, busy4}, 32'h1);
        check("t6_no_done", {31'h0, done4}, 32'h0);
        tick();
        check("t6_done", {31'h0, done4}, 32'h1);
        check("t6_diff", {28'h0, diff4}, 32'hF);
        check("t6_bout", {31'h0, bout4}, 32'h1);
        $display("op t6: a=1 b=2 bin=0 -> diff=%h bout=%0d", diff4, bout4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_nibble_subtractor.md
Name: serial_nibble_subtractor

Overview:
Multi-cycle wide subtractor that computes a - b - bin for WIDTH-bit operands. It processes one 4-bit slice per clock, least-significant slice first, and carries the borrow between slices in a register. It sits upstream of result consumers and reuses the team's 4-bit full-subtractor slice as its datapath, so wide operands cost one slice of area rather than WIDTH/4 slices. Operation uses a start/ready/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4, derived slice count; not overridable

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only on a clk edge where ready=1
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
bin  input  1  borrow-in to slice 0; sampled on the accepting edge only
ready  output  1  high in IDLE and DONE
busy  output  1  high in RUN
done  output  1  one-cycle pulse; high exactly while in DONE
diff  output  WIDTH  result a - b - bin mod 2^WIDTH
bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (rst=1 at an edge, any state):
  - state=IDLE, slice counter=0, borrow register=0, operand registers=0.
  - diff=0, bout=0, done=0, busy=0, ready=1.
  - Reset overrides start on the same edge.
  - Reset mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1:
  - Latch a and b, set borrow register to bin, counter=0, clear diff and bout to 0.
  - Next state RUN.
- RUN, each edge:
  - Slice i = counter. Compute {bo, d} from a[4i+3:4i] - b[4i+3:4i] - borrow, with a 5-bit intermediate; bo is the sign/borrow.
  - Write d into diff[4i+3:4i], set borrow register to bo, counter+1.
  - On the edge processing slice NSLICE-1: bout=bo, next state DONE, counter wraps to 0.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: if start=1, accept exactly as from IDLE (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: done is high in the cycle following the NSLICE-th edge after the accepting edge (16-bit: accept at edge 0, done high after edge 4). Throughput is one result per NSLICE+1 cycles with back-to-back starts.
- start while busy=1 is ignored: not queued, no effect on operands.
- diff and bout may show partial values during RUN. They are valid when done=1 and hold unchanged in IDLE until the next accepted start or reset.
- bin only affects slice 0; inter-slice borrow comes solely from the register.
- No other inputs are sampled outside the accepting edge. Changing a/b/bin during RUN has no effect.

Decomposition:
- Package serial_sub_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - SLICE_W=4 constant
  - function for counter width = clog2(NSLICE), minimum 1
- One sub-module, sub_slice4: combinational 4-bit subtractor with inputs x[3:0], y[3:0], bi and outputs d[3:0], bo. Instantiated once; it is the only arithmetic in the block.
- Top block holds the FSM, counter, operand/borrow registers and result register.

Test Plan:
1. WIDTH=16, a=0x1234, b=0x0234, bin=0, start pulse at edge 0 -> done high after edge 4 only; diff=0x1000, bout=0; ready=0 during edges 1-4.
2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1. Then a=0x0001, b=0x0001, bin=1 -> diff=0xFFFF, bout=1 (borrow ripples through all 4 slices).
3. a=0xFFFF, b=0x5555, bin=0 -> diff=0xAAAA, bout=0. Then assert start with a=0x0000 during the second RUN cycle -> ignored; result still 0xAAAA.
4. Start a=0x8000, b=0x0001, then assert rst for one edge at the third RUN edge -> diff=0, bout=0, ready=1, no done pulse. A new start afterwards completes normally with 0x0005-0x0003 -> 0x0002.
5. Back-to-back: hold start=1 with a new operand set during the DONE cycle -> second operation accepted immediately; two done pulses exactly 5 cycles apart, each with the correct diff.
6. WIDTH=4 instance: a=0x1, b=0x2, bin=0 -> done one edge after the first RUN edge; diff=0xF, bout=1.
